// File: rtl/vga_pmod_out_pkg.sv
// Shared constants for the VGA PMOD output stage: PMOD bit positions, idle byte,
// the 2x2 Bayer threshold table and the PMOD byte packer.
package vga_pmod_out_pkg;

    localparam int         PMOD_HS_BIT = 7;
    localparam int         PMOD_VS_BIT = 3;
    localparam logic [7:0] PMOD_IDLE   = 8'h88;

    typedef logic [1:0] ch2_t;

    typedef struct packed {
        ch2_t b;
        ch2_t g;
        ch2_t r;
    } rgb2_t;

    // Entry i lives at bits [2i+1:2i]: B[0..3] = {0,2,3,1}
    localparam logic [7:0] BAYER_2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic ch2_t bayer(input logic [1:0] idx);
        return BAYER_2X2[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [7:0] pmod_pack(input logic hs_n, input logic vs_n, input rgb2_t c);
        logic [7:0] p;
        p                       = '0;
        p[PMOD_HS_BIT]          = hs_n;
        p[PMOD_HS_BIT-1 -: 3]   = {c.b[0], c.g[0], c.r[0]};
        p[PMOD_VS_BIT]          = vs_n;
        p[PMOD_VS_BIT-1 -: 3]   = {c.b[1], c.g[1], c.r[1]};
        return p;
    endfunction

endpackage

// File: rtl/vga_pmod_out_if.sv
// Pixel bus from the renderer into the PMOD output stage.
interface vga_pmod_out_if #(
    parameter int CH_IN_BITS = 3
);
    logic                    hsync_n;
    logic                    vsync_n;
    logic                    visible;
    logic [3*CH_IN_BITS-1:0] rgb;

    modport master (output hsync_n, vsync_n, visible, rgb);
    modport slave  (input  hsync_n, vsync_n, visible, rgb);
endinterface

// File: rtl/vga_dither_ch.sv
// One colour channel reducer: (v + d) >> D, saturated to 2 bits.
module vga_dither_ch #(
    parameter int CH_IN_BITS = 3
) (
    input  logic [CH_IN_BITS-1:0] v,
    input  logic [1:0]            d,
    output logic [1:0]            o
);
    localparam int D  = CH_IN_BITS - 2;
    localparam int SW = CH_IN_BITS + 1;

    function automatic logic [1:0] sat2(input logic [SW-1:0] x);
        return (x > SW'(3)) ? 2'd3 : x[1:0];
    endfunction

    logic [SW-1:0] sum;
    logic [SW-1:0] shifted;

    always_comb begin
        sum     = {1'b0, v} + SW'(d);
        shifted = sum >> D;
        o       = sat2(shifted);
    end
endmodule

// File: rtl/vga_pmod_out.sv
// Registers renderer syncs/colour into the TinyTapeout VGA PMOD byte, 1 clk latency.
// Define VGA_PMOD_DITHER_EN to build ordered (spatial + frame-alternating) dithering.
module vga_pmod_out
    import vga_pmod_out_pkg::*;
#(
    parameter int CH_IN_BITS     = 3,
    parameter int X_CNT_BITS     = 10,
    parameter int FRAME_CNT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_pmod_out_if.slave        vid,
    output logic [7:0]           uo_out
);
    localparam int D = CH_IN_BITS - 2;

    logic [1:0]            dith;
    rgb2_t                 col;
    logic [7:0]            uo_out_d;
    logic [7:0]            uo_out_q;
    logic [CH_IN_BITS-1:0] v_r, v_g, v_b;

    assign {v_b, v_g, v_r} = vid.rgb;

`ifdef VGA_PMOD_DITHER_EN
    logic [X_CNT_BITS-1:0]     x_cnt_d, x_cnt_q;
    logic                      y_cnt_d, y_cnt_q;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_d, frame_cnt_q;
    logic                      hs_prev_d, hs_prev_q;
    logic                      vs_prev_d, vs_prev_q;
    logic                      hs_fall, vs_fall;
    logic                      unused_cnt_bits;

    always_comb begin
        hs_fall   = hs_prev_q & ~vid.hsync_n;
        vs_fall   = vs_prev_q & ~vid.vsync_n;
        hs_prev_d = vid.hsync_n;
        vs_prev_d = vid.vsync_n;

        if (!vid.hsync_n)  x_cnt_d = '0;
        else if (&x_cnt_q) x_cnt_d = x_cnt_q;
        else               x_cnt_d = x_cnt_q + X_CNT_BITS'(1);

        // vsync low forces parity to 0 even if an hsync edge lands in the same clk
        if (!vid.vsync_n) y_cnt_d = 1'b0;
        else              y_cnt_d = y_cnt_q ^ hs_fall;

        frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(vs_fall);

        // Index uses the counters as they were before this clk's update
        dith = 2'(bayer({y_cnt_q, x_cnt_q[0] ^ frame_cnt_q[0]}) >> (2 - D));
    end

    assign unused_cnt_bits = ^{x_cnt_q, frame_cnt_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt_q     <= '0;
            y_cnt_q     <= 1'b0;
            frame_cnt_q <= '0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
        end
    end
`else
    assign dith = 2'd0;
`endif

    vga_dither_ch #(.CH_IN_BITS(CH_IN_BITS)) u_dith_r (.v(v_r), .d(dith), .o(col.r));
    vga_dither_ch #(.CH_IN_BITS(CH_IN_BITS)) u_dith_g (.v(v_g), .d(dith), .o(col.g));
    vga_dither_ch #(.CH_IN_BITS(CH_IN_BITS)) u_dith_b (.v(v_b), .d(dith), .o(col.b));

    always_comb begin
        uo_out_d = pmod_pack(vid.hsync_n, vid.vsync_n, vid.visible ? col : '0);
    end

    // Output register: syncs and colour share one flop stage so they never skew
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) uo_out_q <= PMOD_IDLE;
        else          uo_out_q <= uo_out_d;
    end

    assign uo_out = uo_out_q;
endmodule

// File: tb/tb_vga_pmod_out.sv
// Directed bench for vga_pmod_out; expectations switch with VGA_PMOD_DITHER_EN.
module tb_vga_pmod_out;

`ifdef VGA_PMOD_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] uo_out;
    int         n_checks;
    int         n_errors;

    vga_pmod_out_if #(.CH_IN_BITS(3)) vif ();

    vga_pmod_out #(
        .CH_IN_BITS    (3),
        .X_CNT_BITS    (10),
        .FRAME_CNT_BITS(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .vid    (vif),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive one pixel just after an edge, then sample 1 time unit after the next edge
    task automatic step(input logic hs, input logic vs, input logic vis, input logic [8:0] c);
        vif.hsync_n = hs;
        vif.vsync_n = vs;
        vif.visible = vis;
        vif.rgb     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        vif.hsync_n = 1'b0;
        vif.vsync_n = 1'b0;
        vif.visible = 1'b1;
        vif.rgb     = 9'h1A5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", uo_out, 8'h88);
        vif.rgb     = 9'h05A;
        vif.hsync_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold", uo_out, 8'h88);

        // Release reset, then check one-clock hsync latency
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 9'h000);
        chk("post_rst", uo_out, 8'h88);
        vif.hsync_n = 1'b0;
        #1;
        chk("hs_not_yet", {7'd0, uo_out[7]}, 8'd1);
        @(posedge clk);
        #1;
        chk("hs_1clk", {7'd0, uo_out[7]}, 8'd0);

        step(1'b1, 1'b1, 1'b1, 9'b111_011_100);
        chk("colour_b7g3r4", uo_out, DITH ? 8'hCF : 8'hED);
        step(1'b0, 1'b1, 1'b0, 9'h1FF);
        chk("blank_hs_low", uo_out, 8'h08);
        step(1'b1, 1'b0, 1'b1, 9'b001_010_110);
        chk("colour_b1g2r6", uo_out, 8'hB1);

        // Async reset from a non-idle output
        vif.hsync_n = 1'b0;
        vif.vsync_n = 1'b0;
        vif.visible = 1'b0;
        vif.rgb     = 9'h000;
        reset_n     = 1'b0;
        #1;
        chk("async_rst_a", uo_out, 8'h88);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 9'h000);
        chk("both_sync_low", uo_out, 8'h00);

        // Mid-grey v=3, frame 0, line parity 0
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f0_x0", uo_out, 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f0_x1", uo_out, DITH ? 8'h8F : 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f0_x2", uo_out, 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f0_x3", uo_out, DITH ? 8'h8F : 8'hF8);

        // vsync falling edge advances the frame, then hsync restarts the line
        step(1'b1, 1'b0, 1'b0, 9'h000);
        chk("vs_low_blank", uo_out, 8'h80);
        step(1'b0, 1'b0, 1'b0, 9'h000);
        chk("hs_vs_low", uo_out, 8'h00);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f1_x0", uo_out, DITH ? 8'h8F : 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f1_x1", uo_out, 8'hF8);

        // Next line (odd parity) in frame 1
        step(1'b0, 1'b1, 1'b0, 9'h000);
        chk("hs_pulse", uo_out, 8'h08);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f1_y1_x0", uo_out, 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("grey_f1_y1_x1", uo_out, DITH ? 8'h8F : 8'hF8);

        // Full scale never wraps, zero stays zero
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 9'h1FF);
            chk($sformatf("white_%0d", i), uo_out, 8'hFF);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 9'h000);
            chk($sformatf("black_%0d", i), uo_out, 8'h88);
        end

        // Reset mid-line at x=300, then the frame-0 pattern resumes from x=0
        step(1'b0, 1'b1, 1'b0, 9'h000);
        chk("line_start", uo_out, 8'h08);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 9'h1FF);
        chk("mid_line", uo_out, 8'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_mid", uo_out, 8'h88);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("resume_x0", uo_out, 8'hF8);
        step(1'b1, 1'b1, 1'b1, 9'h0DB);
        chk("resume_x1", uo_out, DITH ? 8'h8F : 8'hF8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
